// File: rtl/eth_fcs_inserter_if.sv
// Byte-stream handshake bundle (data/valid/last with ready back-pressure).
// The master drives the payload and the slave returns ready.
interface eth_fcs_inserter_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/eth_fcs_inserter.sv
// Ethernet TX framer: echoes payload bytes, zero-pads short frames, appends the
// 4-byte IEEE 802.3 FCS, then holds off input for the inter-frame gap.
module eth_fcs_inserter #(
    parameter bit          PAD_EN     = 1'b1,
    parameter int unsigned MIN_LEN    = 60,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst,
    eth_fcs_inserter_if.slave  s_if,
    eth_fcs_inserter_if.master m_if,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned GAP_W    = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_GAP} state_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = b[i];
        return r;
    endfunction

    // MSB-first byte-wide CRC-32 next state
    function automatic logic [31:0] crc_step(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    state_t           r_state;
    logic [31:0]      r_crc;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [2:0]       r_fcs_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [15:0]      r_frame_cnt;
    logic [7:0]       r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_busy;

    logic             w_out_free;
    logic             w_s_ready;
    logic             w_s_fire;
    logic [7:0]       w_in_byte;
    logic [31:0]      w_crc_base;
    logic [31:0]      w_crc_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    state_t           w_end_state;
    logic [31:0]      w_fcs;
    logic [7:0]       w_fcs_byte;

    // One-deep output register: refill allowed when empty or draining this cycle
    assign w_out_free  = !r_m_valid || m_if.ready;
    assign w_s_ready   = !rst && ((r_state == S_IDLE) || (r_state == S_DATA)) && w_out_free;
    assign w_s_fire    = s_if.valid && w_s_ready;

    assign w_in_byte   = (r_state == S_PAD) ? 8'h00 : s_if.data;
    assign w_crc_base  = (r_state == S_IDLE) ? CRC_SEED : r_crc;
    assign w_crc_next  = crc_step(bitrev8(w_in_byte), w_crc_base);
    assign w_cnt_base  = (r_state == S_IDLE) ? '0 : r_byte_cnt;
    assign w_cnt_next  = (w_cnt_base == CNT_MAX) ? CNT_MAX : w_cnt_base + CNT_W'(1);
    assign w_end_state = (PAD_EN && (w_cnt_next < MIN_CNT)) ? S_PAD : S_FCS;
    assign w_fcs       = ~bitrev32(r_crc);

    // FCS goes out least-significant byte first
    always_comb begin
        w_fcs_byte = w_fcs[7:0];
        case (r_fcs_idx[1:0])
            2'd0:    w_fcs_byte = w_fcs[7:0];
            2'd1:    w_fcs_byte = w_fcs[15:8];
            2'd2:    w_fcs_byte = w_fcs[23:16];
            default: w_fcs_byte = w_fcs[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_crc       <= CRC_SEED;
            r_byte_cnt  <= '0;
            r_fcs_idx   <= '0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (m_if.ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_crc      <= CRC_SEED;
                    r_byte_cnt <= '0;
                    r_fcs_idx  <= '0;
                    if (w_s_fire) begin
                        r_m_data   <= s_if.data;
                        r_m_valid  <= 1'b1;
                        r_m_last   <= 1'b0;
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_next;
                        r_busy     <= 1'b1;
                        r_state    <= s_if.last ? w_end_state : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_s_fire) begin
                        r_m_data   <= s_if.data;
                        r_m_valid  <= 1'b1;
                        r_m_last   <= 1'b0;
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_next;
                        if (s_if.last) r_state <= w_end_state;
                    end
                end
                S_PAD: begin
                    if (w_out_free) begin
                        r_m_data   <= 8'h00;
                        r_m_valid  <= 1'b1;
                        r_m_last   <= 1'b0;
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_next;
                        if (w_cnt_next == MIN_CNT) r_state <= S_FCS;
                    end
                end
                S_FCS: begin
                    if (!r_fcs_idx[2]) begin
                        if (w_out_free) begin
                            r_m_data  <= w_fcs_byte;
                            r_m_valid <= 1'b1;
                            r_m_last  <= (r_fcs_idx == 3'd3);
                            r_fcs_idx <= r_fcs_idx + 3'd1;
                        end
                    end else if (m_if.ready) begin
                        // final FCS byte accepted by the sink
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_gap_cnt   <= '0;
                        if (IFG_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.ready = w_s_ready;
    assign m_if.data  = r_m_data;
    assign m_if.valid = r_m_valid;
    assign m_if.last  = r_m_last;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Bench for eth_fcs_inserter: two instances (no padding / padding to 60), table of
// directed frames, reset abort, inter-frame gap, and random frames vs a reflected-CRC model.
module tb_eth_fcs_inserter;

    typedef logic [7:0] u8_t;
    typedef struct packed { logic [7:0] d; logic l; } rx_t;
    typedef struct {
        bit          sel;
        int unsigned len;
        logic [7:0]  first;
        bit          hs;
        bit          kv;
        logic [31:0] kfcs;
    } vec_t;

    localparam int unsigned TB_MIN = 60;
    localparam int unsigned TB_IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tb_s_data = 8'h00;
    logic        tb_s_valid = 1'b0;
    logic        tb_s_last = 1'b0;
    logic        tb_m_ready = 1'b1;
    bit          sel = 1'b0;
    bit          rnd_ready = 1'b0;
    logic        busy0, busy1;
    logic [15:0] fc0, fc1;

    int checks = 0;
    int errors = 0;
    int exp_fc[2];
    rx_t rx_q[$];
    u8_t exp_q[$];

    eth_fcs_inserter_if s0();
    eth_fcs_inserter_if m0();
    eth_fcs_inserter_if s1();
    eth_fcs_inserter_if m1();

    assign s0.data  = tb_s_data;
    assign s0.last  = tb_s_last;
    assign s0.valid = tb_s_valid && !sel;
    assign m0.ready = sel ? 1'b1 : tb_m_ready;
    assign s1.data  = tb_s_data;
    assign s1.last  = tb_s_last;
    assign s1.valid = tb_s_valid && sel;
    assign m1.ready = sel ? tb_m_ready : 1'b1;

    eth_fcs_inserter #(.PAD_EN(1'b0), .MIN_LEN(TB_MIN), .IFG_CYCLES(TB_IFG)) dut0 (
        .clk(clk), .rst(rst), .s_if(s0.slave), .m_if(m0.master), .busy(busy0), .frame_cnt(fc0));
    eth_fcs_inserter #(.PAD_EN(1'b1), .MIN_LEN(TB_MIN), .IFG_CYCLES(TB_IFG)) dut1 (
        .clk(clk), .rst(rst), .s_if(s1.slave), .m_if(m1.master), .busy(busy1), .frame_cnt(fc1));

    wire        w_s_ready = sel ? s1.ready : s0.ready;
    wire        w_m_valid = sel ? m1.valid : m0.valid;
    wire [7:0]  w_m_data  = sel ? m1.data  : m0.data;
    wire        w_m_last  = sel ? m1.last  : m0.last;
    wire        w_busy    = sel ? busy1 : busy0;
    wire [15:0] w_fc      = sel ? fc1 : fc0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Sink side: random back-pressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        tb_m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: records transfers and checks stability while stalled
    initial begin
        bit  prev_stall = 1'b0;
        u8_t prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(w_m_valid), 32'd1);
                    chk("stall_data", 32'(w_m_data), 32'(prev_data));
                end
                if (w_m_valid && tb_m_ready) rx_q.push_back('{d: w_m_data, l: w_m_last});
                prev_stall = w_m_valid && !tb_m_ready;
                prev_data  = w_m_data;
            end
        end
    end

    // Reference: payload, zero pad, then reflected CRC-32 (poly 0xEDB88320) sent LSB byte first
    task automatic model(input u8_t p[$], input bit pad);
        logic [31:0] c;
        exp_q = p;
        if (pad) while (exp_q.size() < int'(TB_MIN)) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (exp_q[k]) begin
            c ^= {24'h0, exp_q[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic drive_bytes(input u8_t p[$], input bit hs, input bit end_frame);
        int i = 0;
        int guard = 0;
        while (i < p.size() && guard < 5000) begin
            @(posedge clk);
            #1;
            tb_s_valid = hs ? 1'($urandom_range(0, 1)) : 1'b1;
            tb_s_data  = p[i];
            tb_s_last  = end_frame && (i == p.size() - 1);
            @(negedge clk);
            if (tb_s_valid && w_s_ready) i++;
            guard++;
        end
        if (i < p.size()) chk("drive_timeout", 32'(i), 32'(p.size()));
        @(posedge clk);
        #1;
        tb_s_valid = 1'b0;
        tb_s_last  = 1'b0;
    endtask

    task automatic run_frame(input bit s, input u8_t p[$], input bit hs,
                             input bit kv, input logic [31:0] kfcs);
        int n;
        int g;
        sel = s;
        rnd_ready = hs;
        rx_q.delete();
        model(p, s);
        drive_bytes(p, hs, 1'b1);
        for (int k = 0; k < 4000 && rx_q.size() < exp_q.size(); k++) begin
            @(negedge clk);
            #1;
        end
        n = rx_q.size();
        chk("out_len", 32'(n), 32'(exp_q.size()));
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            chk("out_byte", 32'(rx_q[k].d), 32'(exp_q[k]));
            chk("out_last", 32'(rx_q[k].l), 32'(k == exp_q.size() - 1));
        end
        if (kv && n >= 4) chk("fcs_known", {rx_q[n-1].d, rx_q[n-2].d, rx_q[n-3].d, rx_q[n-4].d}, kfcs);
        rnd_ready = 1'b0;
        // Input must stay held off for exactly the gap after the last FCS transfer
        g = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (w_s_ready) break;
            g++;
        end
        chk("gap_len", 32'(g), 32'(TB_IFG));
        exp_fc[s] = (exp_fc[s] + 1) % 65536;
        chk("frame_cnt", 32'(w_fc), 32'(exp_fc[s]));
        chk("busy_idle", 32'(w_busy), 32'd0);
    endtask

    initial begin
        vec_t vt[8];
        u8_t  p[$];

        vt[0] = '{sel: 1'b0, len: 9,  first: 8'h31, hs: 1'b0, kv: 1'b1, kfcs: 32'hCBF4_3926};
        vt[1] = '{sel: 1'b0, len: 1,  first: 8'h00, hs: 1'b0, kv: 1'b1, kfcs: 32'hD202_EF8D};
        vt[2] = '{sel: 1'b1, len: 9,  first: 8'h31, hs: 1'b0, kv: 1'b0, kfcs: 32'h0};
        vt[3] = '{sel: 1'b0, len: 9,  first: 8'h31, hs: 1'b1, kv: 1'b1, kfcs: 32'hCBF4_3926};
        vt[4] = '{sel: 1'b1, len: 60, first: 8'h00, hs: 1'b0, kv: 1'b0, kfcs: 32'h0};
        vt[5] = '{sel: 1'b1, len: 59, first: 8'h10, hs: 1'b1, kv: 1'b0, kfcs: 32'h0};
        vt[6] = '{sel: 1'b1, len: 61, first: 8'hF0, hs: 1'b1, kv: 1'b0, kfcs: 32'h0};
        vt[7] = '{sel: 1'b1, len: 1,  first: 8'hA5, hs: 1'b0, kv: 1'b0, kfcs: 32'h0};
        exp_fc[0] = 0;
        exp_fc[1] = 0;

        // Reset state, sampled while reset is still asserted
        @(negedge clk);
        chk("rst_s_ready0", 32'(s0.ready), 32'd0);
        chk("rst_s_ready1", 32'(s1.ready), 32'd0);
        chk("rst_m_valid", 32'(m0.valid | m1.valid), 32'd0);
        chk("rst_m_last", 32'(m0.last | m1.last), 32'd0);
        chk("rst_m_data", 32'({m0.data, m1.data}), 32'd0);
        chk("rst_busy", 32'(busy0 | busy1), 32'd0);
        chk("rst_frame_cnt", 32'({fc0, fc1}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(s0.ready & s1.ready), 32'd1);

        foreach (vt[v]) begin
            p.delete();
            for (int j = 0; j < int'(vt[v].len); j++) p.push_back(8'(vt[v].first + 8'(j)));
            run_frame(vt[v].sel, p, vt[v].hs, vt[v].kv, vt[v].kfcs);
        end

        // Reset after the 5th payload byte aborts the frame without a partial FCS
        sel = 1'b0;
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        drive_bytes(p, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fc[0] = 0;
        exp_fc[1] = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_m_valid", 32'(m0.valid), 32'd0);
        end
        chk("post_rst_busy", 32'(busy0), 32'd0);
        chk("post_rst_frame_cnt", 32'(fc0), 32'd0);
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(1'b0, p, 1'b0, 1'b1, 32'hCBF4_3926);

        // Random frames on both instances with random handshakes
        for (int f = 0; f < 10; f++) begin
            int unsigned len;
            bit s;
            bit hs;
            s   = 1'($urandom_range(0, 1));
            hs  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 75);
            p.delete();
            for (int j = 0; j < int'(len); j++) p.push_back(8'($urandom));
            run_frame(s, p, hs, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
